// File: rtl/slice_mux.sv
// rtl/slice_mux.sv - round-robin byte packer of per-slice chunk streams into one 256-bit stream
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous clear of all state (wins over every other event)
//   slices_per_line    active slices (1 = bypass mode), static within a frame
//   chunk_size         bytes per chunk, static within a frame
//   in_sof, in_eof     frame start pulse / frame end pulse (pads the last partial word)
//   in_data_p          slice s word at [s*256+:256], byte i at [i*8+:8]
//   in_valid/in_ready  per-slice input handshake; only the active slice can be ready
//   out_data/out_valid/out_ready  packed output word, byte 0 is the earliest byte
//   out_sof            first output word of a frame

module slice_mux #(
    parameter int MAX_NBR_SLICES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [9:0]                    slices_per_line,
    input  logic [15:0]                   chunk_size,
    input  logic                          in_sof,
    input  logic                          in_eof,
    input  logic [256*MAX_NBR_SLICES-1:0] in_data_p,
    input  logic [MAX_NBR_SLICES-1:0]     in_valid,
    output logic [MAX_NBR_SLICES-1:0]     in_ready,
    output logic [255:0]                  out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sof
);

    localparam int AW = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1;

    // Accumulator holds up to 63 valid bytes; byte 0 is the oldest.
    logic [511:0]  acc;
    logic [6:0]    fill;
    logic [AW-1:0] active;
    // Bytes already taken from the current chunk. Tracking the consumed count
    // instead of the remaining count lets reset load a constant while the
    // effective remaining count still equals chunk_size after reset or flush.
    logic [15:0]   chunk_used;
    logic          pad_pending;
    logic          sof_pending;

    logic          single_mode;
    logic [15:0]   chunk_rem;
    logic          can_push;
    logic          full_word;
    logic          pop;
    logic          pad_pop;
    logic [6:0]    pop_bytes;
    logic          push;
    logic [255:0]  push_word;
    logic [5:0]    push_bytes;
    logic [5:0]    push_n;
    logic          chunk_done;
    logic [6:0]    wr_off;
    logic [511:0]  acc_base;
    logic [511:0]  wr_data;
    logic [63:0]   wr_mask;
    logic [511:0]  acc_next;
    logic [6:0]    fill_next;
    logic [9:0]    active_inc;
    logic [AW-1:0] active_next;

    assign single_mode = (slices_per_line <= 10'd1);
    assign chunk_rem   = chunk_size - chunk_used;
    assign can_push    = (fill < 7'd32) | out_ready;
    assign full_word   = (fill >= 7'd32);
    assign out_valid   = full_word | (pad_pending & (fill != 7'd0));
    assign pop         = out_valid & out_ready;
    // A pop with less than a full word buffered is the zero-padded tail word.
    assign pad_pop     = pop & ~full_word;
    assign out_sof     = sof_pending;

    always_comb begin
        pop_bytes = 7'd0;
        if (pop) begin
            pop_bytes = full_word ? 7'd32 : fill;
        end
    end

    always_comb begin
        in_ready  = '0;
        push_word = '0;
        for (int s = 0; s < MAX_NBR_SLICES; s++) begin
            if (active == AW'(s)) begin
                in_ready[s] = can_push;
                push_word   = in_data_p[s*256 +: 256];
            end
        end
    end

    assign push = |(in_valid & in_ready);

    // Bytes a word contributes: whole word in bypass mode, otherwise the
    // remainder of the current chunk capped at one word.
    always_comb begin
        push_bytes = 6'd32;
        if (!single_mode && (chunk_rem < 16'd32)) begin
            push_bytes = chunk_rem[5:0];
        end
    end

    assign push_n     = push ? push_bytes : 6'd0;
    assign chunk_done = push & ~single_mode & ({10'd0, push_bytes} == chunk_rem);

    // New bytes land directly after the bytes that survive this cycle's pop.
    assign wr_off = fill - pop_bytes;

    always_comb begin
        acc_base = acc;
        if (pad_pop) begin
            acc_base = '0;
        end else if (pop) begin
            acc_base = {256'd0, acc[511:256]};
        end
    end

    assign wr_data = {256'd0, push_word} << {wr_off, 3'b000};
    assign wr_mask = ((64'd1 << push_n) - 64'd1) << wr_off;

    always_comb begin
        acc_next = acc_base;
        for (int i = 0; i < 64; i++) begin
            if (wr_mask[i]) begin
                acc_next[i*8 +: 8] = wr_data[i*8 +: 8];
            end
        end
    end

    assign fill_next = wr_off + {1'b0, push_n};

    assign active_inc = {{(10-AW){1'b0}}, active} + 10'd1;

    always_comb begin
        active_next = active_inc[AW-1:0];
        if (active_inc >= slices_per_line) begin
            active_next = '0;
        end
    end

    // Output bytes beyond the fill level are forced to zero so a padded tail
    // word carries zeros rather than stale accumulator contents.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < 32; i++) begin
            if (7'(i) < fill) begin
                out_data[i*8 +: 8] = acc[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            fill        <= '0;
            active      <= '0;
            chunk_used  <= '0;
            pad_pending <= 1'b0;
            sof_pending <= 1'b0;
        end else if (flush) begin
            acc         <= '0;
            fill        <= '0;
            active      <= '0;
            chunk_used  <= '0;
            pad_pending <= 1'b0;
            sof_pending <= 1'b0;
        end else begin
            acc  <= acc_next;
            fill <= fill_next;

            if (in_sof) begin
                active     <= '0;
                chunk_used <= '0;
            end else if (chunk_done) begin
                active     <= active_next;
                chunk_used <= '0;
            end else if (push && !single_mode) begin
                chunk_used <= chunk_used + {10'd0, push_n};
            end

            // An end-of-frame with nothing buffered simply lapses next cycle.
            if (in_eof) begin
                pad_pending <= 1'b1;
            end else if (pad_pop || (fill == 7'd0)) begin
                pad_pending <= 1'b0;
            end

            if (in_sof) begin
                sof_pending <= 1'b1;
            end else if (pop) begin
                sof_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_slice_mux.sv
// tb/tb_slice_mux.sv - self-checking bench for slice_mux against a byte-queue reference model

module tb_slice_mux;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [9:0]   slices_per_line;
    logic [15:0]  chunk_size;
    logic         in_sof;
    logic         in_eof;
    logic [511:0] in_data_p;
    logic [1:0]   in_valid;
    logic [1:0]   in_ready;
    logic [255:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sof;

    slice_mux #(.MAX_NBR_SLICES(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .slices_per_line (slices_per_line),
        .chunk_size      (chunk_size),
        .in_sof          (in_sof),
        .in_eof          (in_eof),
        .in_data_p       (in_data_p),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sof         (out_sof)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: bytes accepted but not yet emitted, plus frame bookkeeping.
    logic [7:0]   ref_q[$];
    int           m_active;
    int           m_used;
    bit           m_pad;
    bit           m_sof;

    logic [255:0] out_log[$];
    logic         sof_log[$];

    logic [1:0]   snap_ready;
    logic [1:0]   snap_acc;
    logic         snap_valid;
    logic [255:0] snap_data;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] seq_word(input int start);
        logic [255:0] w;
        for (int i = 0; i < 32; i++) w[i*8 +: 8] = 8'(start + i);
        return w;
    endfunction

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic model_clear();
        ref_q.delete();
        m_active = 0;
        m_used   = 0;
        m_pad    = 0;
        m_sof    = 0;
    endtask

    // One clock: check DUT outputs at the falling edge against the model,
    // advance the model by the rules, then return just after the rising edge.
    task automatic cycle();
        int           sz;
        int           n;
        int           k;
        bit           exp_valid;
        logic [1:0]   exp_ready;
        logic [255:0] exp_data;
        logic [255:0] w;
        @(negedge clk);
        sz = ref_q.size();
        if (m_pad && sz == 0) m_pad = 0;
        exp_valid = (sz >= 32) || (m_pad && sz > 0);
        exp_ready = ((sz < 32) || out_ready) ? 2'(1 << m_active) : 2'b00;
        exp_data  = '0;
        for (int i = 0; i < 32 && i < sz; i++) exp_data[i*8 +: 8] = ref_q[i];

        snap_ready = in_ready;
        snap_valid = out_valid;
        snap_data  = out_data;
        snap_acc   = in_valid & exp_ready;

        chk("in_ready", 256'(in_ready), 256'(exp_ready));
        chk("out_valid", 256'(out_valid), 256'(exp_valid));
        chk("out_data", out_data, exp_data);
        if (exp_valid) chk("out_sof", 256'(out_sof), 256'(m_sof));

        if (flush) begin
            model_clear();
        end else begin
            if (exp_valid && out_ready) begin
                out_log.push_back(out_data);
                sof_log.push_back(out_sof);
                k = (sz >= 32) ? 32 : sz;
                for (int i = 0; i < k; i++) void'(ref_q.pop_front());
                if (sz < 32) m_pad = 0;
                m_sof = 0;
            end
            if (snap_acc != 2'b00) begin
                w = in_data_p[m_active*256 +: 256];
                if (slices_per_line == 10'd1) begin
                    n = 32;
                end else begin
                    n = int'(chunk_size) - m_used;
                    if (n > 32) n = 32;
                end
                for (int i = 0; i < n; i++) ref_q.push_back(w[i*8 +: 8]);
                if (slices_per_line != 10'd1) begin
                    m_used += n;
                    if (m_used == int'(chunk_size)) begin
                        m_used   = 0;
                        m_active = (m_active + 1) % int'(slices_per_line);
                    end
                end
            end
            if (in_eof) m_pad = 1;
            if (in_sof) begin
                m_active = 0;
                m_used   = 0;
                m_sof    = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [255:0] w);
        bit done = 0;
        in_valid[s] = 1'b1;
        in_data_p[s*256 +: 256] = w;
        for (int t = 0; t < 50 && !done; t++) begin
            cycle();
            if (snap_acc[s]) done = 1;
        end
        in_valid[s] = 1'b0;
        chk("send_timeout", 256'(done), 256'(1));
    endtask

    task automatic pulse_sof();
        in_sof = 1'b1;
        cycle();
        in_sof = 1'b0;
    endtask

    task automatic pulse_eof();
        in_eof = 1'b1;
        cycle();
        in_eof = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        in_valid  = 2'b00;
        out_ready = 1'b1;
        for (int t = 0; t < 30 && !done; t++) begin
            cycle();
            if (ref_q.size() == 0 && !m_pad) done = 1;
        end
        chk("drain_timeout", 256'(done), 256'(1));
        cycle();
        chk("drained_valid", 256'(snap_valid), 256'(0));
    endtask

    task automatic setup(input int spl, input int csz);
        slices_per_line = 10'(spl);
        chunk_size      = 16'(csz);
        out_log.delete();
        sof_log.delete();
    endtask

    logic [255:0] w0, w1, w2, hold, exp;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        in_data_p = '0; in_valid = 2'b00; out_ready = 1'b1;
        slices_per_line = 10'd2; chunk_size = 16'd40;
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_data", out_data, 256'(0));
        chk("rst_out_sof", 256'(out_sof), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(2'b01));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Two slices, chunk 40
        setup(2, 40);
        pulse_sof();
        send(0, seq_word(8'h00));
        send(0, seq_word(8'h20));
        send(1, seq_word(8'h80));
        send(1, seq_word(8'hA0));
        cycle();
        chk("t1_ptr_back", 256'(snap_ready), 256'(2'b01));
        pulse_eof();
        drain();
        exp = seq_word(8'h80) << 64;
        exp[63:0] = seq_word(8'h20) & 256'hFFFF_FFFF_FFFF_FFFF;
        chk("t1_nwords", 256'(out_log.size()), 256'(3));
        chk("t1_word0", out_log[0], seq_word(8'h00));
        chk("t1_word1", out_log[1], exp);

        // Single slice bypass, one-cycle latency
        setup(1, 40);
        pulse_sof();
        w0 = rand_word(); w1 = rand_word(); w2 = rand_word();
        in_valid = 2'b01;
        in_data_p[255:0] = w0; cycle();
        chk("t2_lat0", 256'(snap_valid), 256'(0));
        in_data_p[255:0] = w1; cycle();
        chk("t2_lat1", 256'(snap_valid), 256'(1));
        chk("t2_w0", snap_data, w0);
        in_data_p[255:0] = w2; cycle();
        chk("t2_w1", snap_data, w1);
        in_valid = 2'b00; cycle();
        chk("t2_w2", snap_data, w2);
        cycle();
        chk("t2_idle", 256'(snap_valid), 256'(0));

        // Backpressure
        setup(2, 50);
        pulse_sof();
        in_valid = 2'b11; out_ready = 1'b0;
        hold = '0;
        for (int i = 0; i < 10; i++) begin
            in_data_p = {rand_word(), rand_word()};
            cycle();
            if (i == 1) hold = snap_data;
            if (i >= 1) begin
                chk("bp_ready", 256'(snap_ready), 256'(0));
                chk("bp_valid", 256'(snap_valid), 256'(1));
                chk("bp_stable", snap_data, hold);
            end
        end
        for (int i = 0; i < 150; i++) begin
            in_data_p = {rand_word(), rand_word()};
            in_valid  = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid = 2'b00;
        pulse_eof();
        drain();

        // Padding
        setup(2, 5);
        pulse_sof();
        w0 = rand_word(); w1 = rand_word();
        send(0, w0);
        send(1, w1);
        pulse_eof();
        drain();
        exp = '0;
        exp[39:0]  = w0[39:0];
        exp[79:40] = w1[39:0];
        chk("pad_nwords", 256'(out_log.size()), 256'(1));
        chk("pad_word", out_log[0], exp);

        // Frame boundary
        setup(2, 20);
        pulse_sof();
        send(0, rand_word());
        send(1, rand_word());
        send(0, rand_word());
        pulse_eof();
        drain();
        pulse_sof();
        cycle();
        chk("fb_restart", 256'(snap_ready), 256'(2'b01));
        send(0, rand_word());
        pulse_eof();
        drain();
        chk("fb_nwords", 256'(sof_log.size()), 256'(3));
        chk("fb_sof0", 256'(sof_log[0]), 256'(1));
        chk("fb_sof1", 256'(sof_log[1]), 256'(0));
        chk("fb_sof2", 256'(sof_log[2]), 256'(1));

        // Flush with fill=20, active=1
        setup(2, 20);
        pulse_sof();
        send(0, rand_word());
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        chk("fl_valid", 256'(snap_valid), 256'(0));
        chk("fl_ready", 256'(snap_ready), 256'(2'b01));
        pulse_sof();
        w0 = rand_word(); w1 = rand_word();
        send(0, w0);
        send(1, w1);
        pulse_eof();
        drain();
        exp = {w1[95:0], w0[159:0]};
        chk("fl_word0", out_log[0], exp);

        // Randomized frames
        for (int f = 0; f < 4; f++) begin
            setup($urandom_range(1, 2), $urandom_range(1, 80));
            pulse_sof();
            for (int i = 0; i < 120; i++) begin
                in_data_p = {rand_word(), rand_word()};
                in_valid  = ($urandom_range(0, 3) != 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                out_ready = ($urandom_range(0, 3) != 0);
                cycle();
            end
            in_valid = 2'b00;
            pulse_eof();
            drain();
        end

        // Asynchronous reset mid-frame
        setup(2, 40);
        pulse_sof();
        out_ready = 1'b0;
        send(0, rand_word());
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 256'(out_valid), 256'(0));
        chk("arst_data", out_data, 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        out_ready = 1'b1;
        cycle();
        chk("arst_ready", 256'(snap_ready), 256'(2'b01));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/slice_mux.md
# slice_mux

Encoder-side slice multiplexer, the transmit counterpart of the decoder's slice demultiplexer. Accepts one 256-bit chunk stream per slice and byte-packs whole chunks into a single 256-bit output stream in round-robin slice order (slice 0 chunk, slice 1 chunk, …, slice N-1 chunk, repeat). Chunk boundaries are not word-aligned: each chunk begins at the byte immediately after the previous one. Sits between the per-slice rate buffers and the bitstream output.

## Interface
- MAX_NBR_SLICES, 2, number of slice input ports
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all state, highest priority
- slices_per_line  input  10  active slices, 1..MAX_NBR_SLICES, static within a frame
- chunk_size  input  16  bytes per chunk, ≥1, static within a frame
- in_sof  input  1  start-of-frame pulse, never coincident with an input handshake
- in_eof  input  1  end-of-frame pulse, requests padding of the final partial word
- in_data_p  input  256*MAX_NBR_SLICES  slice s word at bits [s*256+:256], byte i at [i*8+:8]
- in_valid  input  MAX_NBR_SLICES  per-slice word valid
- in_ready  output  MAX_NBR_SLICES  per-slice ready, combinational
- out_data  output  256  packed word, byte 0 = earliest byte
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accept
- out_sof  output  1  marks the first output word of a frame, qualified by out_valid

## Operation
- State: 64-byte accumulator `acc`, fill count `fill` (0..63), slice pointer `active`, chunk byte countdown `chunk_rem` (16 bits), `pad_pending`, `sof_pending`.
- Multi-slice mode (slices_per_line > 1):
  - Only slice `active` may handshake. `in_ready[s] = (s==active) & (fill<32 | out_ready)`. All other in_ready bits are 0.
  - An accepted word contributes `n = min(32, chunk_rem)` bytes, taken from its low bytes; upper bytes are discarded.
  - The n bytes are written into acc starting at byte `fill - (pop?32:0)`.
  - `chunk_rem -= n`. When it reaches 0: reload to chunk_size, and advance active (wrap to 0 when active+1 == slices_per_line).
- Single-slice mode (slices_per_line == 1): bypass. Every accepted slice-0 word contributes all 32 bytes, with no chunk counting. active stays 0.
- Output: `out_valid = (fill≥32) | (pad_pending & fill>0)`.
  - out_data = acc bytes 0..31; bytes at index ≥ fill are forced to 0.
  - On pop (out_valid & out_ready), acc shifts down 32 bytes: fill -= 32, or fill = 0 for a padded word. A padded pop clears pad_pending.
- Fill update: `fill_next = fill − pop_bytes + n` (push and pop in the same cycle allowed). Max fill 63, so there is no overflow.
- in_eof sets pad_pending. If fill==0 when in_eof arrives, pad_pending clears the next cycle and no word is emitted.
- in_sof:
  - Resets active=0 and chunk_rem=chunk_size, and sets sof_pending.
  - out_sof = sof_pending; it clears on the first pop.
  - Upstream guarantees the previous frame was drained via in_eof.
- flush (or reset): acc=0, fill=0, active=0, chunk_rem=chunk_size, pad_pending=0, sof_pending=0.

## Timing
- Reset values: out_valid=0, out_data=0, out_sof=0, in_ready=1 on slice 0 only, 0 elsewhere.
- Latency: a word accepted at cycle t that makes fill≥32 gives out_valid=1 at t+1. There is no combinational path from in_data to out_data.
- Throughput: one input word and one output word per cycle when out_ready is held high.
- Backpressure: with out_ready=0 and fill≥32, every in_ready is 0 and out_data/out_valid hold stable.
- The pointer advance on a chunk's last word takes effect the next cycle, so the next slice's first word is accepted no earlier than t+1.
- Simultaneous in_eof and a handshake: bytes are appended first, and padding applies to the resulting fill.
- flush overrides every other event in the same cycle.
- Asynchronous reset mid-frame discards all buffered bytes.

## Test plan
- **Two slices, chunk_size=40.** Stimulus: slice0 sends words with bytes 0x00..0x1F, then 0x20..0x3F; slice1 sends 0x80..0x9F, then 0xA0..0xBF.
  - Word 0 = 0x00..0x1F.
  - Word 1 = 0x20..0x27 followed by 0x80..0x97.
  - Then the pointer returns to slice0.
- **Single slice, chunk_size=40.** Stimulus: 3 words. Required: output is identical to input, all 32 bytes per word, and out_valid lags in_valid by 1 cycle.
- **Backpressure.** Stimulus: hold out_ready=0 for 10 cycles with continuous input.
  - fill saturates between 32 and 63, and in_ready drops to 0.
  - out_data is stable throughout.
  - After release, no bytes are lost or duplicated (compare against a reference byte queue).
- **Padding.** Stimulus: chunk_size=5, two slices, one word each, then in_eof. Required: one output word with bytes 0..4 from slice0, bytes 5..9 from slice1, and bytes 10..31 = 0.
- **Frame boundary.** Stimulus: in_sof, then frame data.
  - out_sof=1 only on the first output word.
  - A second in_sof after in_eof restarts at slice 0, with out_sof asserted again.
- **Flush.** Stimulus: assert flush with fill=20 and active=1. Required: next cycle out_valid=0 and in_ready=01b; a subsequent frame packs from byte 0.
